// File: rtl/mem_access_pkg.sv
// Shared FSM state encoding and I/O-port address map for the memory access initiator.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // 0xFD/0xFE are read-only input ports; 0xFF is a plain writable output port.
  localparam logic [7:0] PORT0_ADDR   = 8'hFD;
  localparam logic [7:0] PORT1_ADDR   = 8'hFE;
  localparam logic [7:0] OUTPORT_ADDR = 8'hFF;

  localparam int LAT_CNT_W = 2;

endpackage

// File: rtl/mem_access_initiator_if.sv
// Request/response handshake plus memory-unit bus; slave = initiator, master = requester/memory side.
interface mem_access_initiator_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_write_en;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_write_en, mem_data_in
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_write_en, mem_data_in
  );

endinterface

// File: rtl/mem_latency_counter.sv
// WAIT-phase down-counter: load sets the count, dec steps it toward 0, done flags the last cycle.
// Latency: registered count, combinational done; no backpressure (driven by the FSM only).
module mem_latency_counter
  import mem_access_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [LAT_CNT_W-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 done_o
);

  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - LAT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LAT_CNT_W'(1));

endmodule

// File: rtl/mem_access_initiator.sv
// Single-outstanding load/store initiator: response 2 cycles after accept (stores) or 2+READ_LATENCY (loads).
// Backpressure: req_ready only in IDLE; a response is held in RESP until rsp_ready.
module mem_access_initiator
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input logic                   clk,
  input logic                   rst,
  mem_access_initiator_if.slave bus
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  cnt_load, cnt_dec, cnt_done;
  logic                  ro_hit;

  assign ro_hit = (addr_q == ADDR_WIDTH'(PORT0_ADDR)) || (addr_q == ADDR_WIDTH'(PORT1_ADDR));

  mem_latency_counter u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (LAT_CNT_W'(READ_LATENCY)),
    .dec_i      (cnt_dec),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          cnt_load = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          rdata_d = '0;
          err_d   = ro_hit;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_done) begin
          rdata_d = bus.mem_data_out;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Write strobe is decoded from state so reset kills it without waiting for an edge.
  assign bus.req_ready    = (state_q == IDLE);
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_err      = err_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_data_in  = wdata_q;
  assign bus.mem_write_en = (state_q == ISSUE) && we_q && !ro_hit;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench: two initiators (READ_LATENCY 1 and 3) share one request stream, each with its own memory model.
module tb_mem_access_initiator;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_wr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_ready = 1'b1;

  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  int          wr1 = 0;
  int          wr3 = 0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          acc_cyc [0:11];
  int          last_acc;

  mem_access_initiator_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus1 ();
  mem_access_initiator_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus3 ();

  assign bus1.req_valid    = req_valid;
  assign bus1.req_we       = req_we;
  assign bus1.req_addr     = req_addr;
  assign bus1.req_wdata    = req_wdata;
  assign bus1.rsp_ready    = rsp_ready;
  assign bus1.mem_data_out = mem1[bus1.mem_addr];
  assign bus3.req_valid    = req_valid;
  assign bus3.req_we       = req_we;
  assign bus3.req_addr     = req_addr;
  assign bus3.req_wdata    = req_wdata;
  assign bus3.rsp_ready    = rsp_ready;
  assign bus3.mem_data_out = mem3[bus3.mem_addr];

  mem_access_initiator #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );
  mem_access_initiator #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(3)) u_dut3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: contents start as 0xA50000<addr>, writes land on the strobe edge.
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'hA500_0000 | 32'(i);
      mem3[i] = 32'hA500_0000 | 32'(i);
    end
    forever begin
      @(posedge clk);
      if (bus1.mem_write_en) begin
        mem1[bus1.mem_addr] <= bus1.mem_data_in;
        wr1 <= wr1 + 1;
      end
      if (bus3.mem_write_en) begin
        mem3[bus3.mem_addr] <= bus3.mem_data_in;
        wr3 <= wr3 + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_txn(input string tag, input vec_t v);
    int          lat1, lat3, w1, w3, n;
    logic [31:0] rd1, rd3;
    logic        e1, e3;
    bit          d1, d3;
    lat1 = 99; lat3 = 99; rd1 = 'x; rd3 = 'x; e1 = 'x; e3 = 'x;
    d1 = 0; d3 = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; rsp_ready = 1'b1;
    chk({tag, " req_ready1"}, 32'(bus1.req_ready), 32'd1);
    chk({tag, " req_ready3"}, 32'(bus3.req_ready), 32'd1);
    w1 = wr1; w3 = wr3;
    @(negedge clk);
    req_valid = 1'b0;
    last_acc = cyc;
    n = 1;
    while (!(d1 && d3) && n <= 20) begin
      if (n == 1) begin
        chk({tag, " mem_addr"}, 32'(bus1.mem_addr), 32'(v.addr));
        chk({tag, " mem_data_in"}, bus1.mem_data_in, v.wdata);
      end
      if (!d1 && bus1.rsp_valid) begin
        d1 = 1; lat1 = n; rd1 = bus1.rsp_rdata; e1 = bus1.rsp_err;
      end
      if (!d3 && bus3.rsp_valid) begin
        d3 = 1; lat3 = n; rd3 = bus3.rsp_rdata; e3 = bus3.rsp_err;
      end
      if (!(d1 && d3)) begin
        @(negedge clk);
        n++;
      end
    end
    chk({tag, " latency RL1"}, 32'(lat1), v.we ? 32'd2 : 32'd3);
    chk({tag, " latency RL3"}, 32'(lat3), v.we ? 32'd2 : 32'd5);
    chk({tag, " rdata RL1"}, rd1, v.exp_rdata);
    chk({tag, " rdata RL3"}, rd3, v.exp_rdata);
    chk({tag, " err RL1"}, 32'(e1), 32'(v.exp_err));
    chk({tag, " err RL3"}, 32'(e3), 32'(v.exp_err));
    chk({tag, " writes RL1"}, 32'(wr1 - w1), 32'(v.exp_wr));
    chk({tag, " writes RL3"}, 32'(wr3 - w3), 32'(v.exp_wr));
  endtask

  vec_t vecs [0:11];
  vec_t v;

  initial begin
    int n;
    int seen;
    vecs[0]  = '{1'b1, 8'h00, 32'h1234_5678, 32'h0000_0000, 1'b0, 1};
    vecs[1]  = '{1'b0, 8'h00, 32'h0000_0000, 32'h1234_5678, 1'b0, 0};
    vecs[2]  = '{1'b1, 8'hFD, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 0};
    vecs[3]  = '{1'b0, 8'hFD, 32'h0000_0000, 32'hA500_00FD, 1'b0, 0};
    vecs[4]  = '{1'b1, 8'hFF, 32'hAABB_CCDD, 32'h0000_0000, 1'b0, 1};
    vecs[5]  = '{1'b0, 8'hFF, 32'h0000_0000, 32'hAABB_CCDD, 1'b0, 0};
    vecs[6]  = '{1'b1, 8'h10, 32'h1111_1111, 32'h0000_0000, 1'b0, 1};
    vecs[7]  = '{1'b1, 8'hC0, 32'h4444_4444, 32'h0000_0000, 1'b0, 1};
    vecs[8]  = '{1'b0, 8'h10, 32'h0000_0000, 32'h1111_1111, 1'b0, 0};
    vecs[9]  = '{1'b0, 8'hC0, 32'h0000_0000, 32'h4444_4444, 1'b0, 0};
    vecs[10] = '{1'b1, 8'hFE, 32'h0BAD_F00D, 32'h0000_0000, 1'b1, 0};
    vecs[11] = '{1'b0, 8'hFE, 32'h0000_0000, 32'hA500_00FE, 1'b0, 0};

    // Reset values while rst is held across clock edges.
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(bus1.req_ready), 32'd1);
    chk("rst rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("rst rsp_err", 32'(bus1.rsp_err), 32'd0);
    chk("rst rsp_rdata", bus1.rsp_rdata, 32'd0);
    chk("rst mem_write_en", 32'(bus1.mem_write_en), 32'd0);
    chk("rst mem_addr", 32'(bus1.mem_addr), 32'd0);
    chk("rst mem_data_in", bus1.mem_data_in, 32'd0);
    chk("rst rsp_valid RL3", 32'(bus3.rsp_valid), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_txn($sformatf("v%0d", i), vecs[i]);
      acc_cyc[i] = last_acc;
    end
    chk("b2b store spacing", 32'(acc_cyc[7] - acc_cyc[6]), 32'd3);
    chk("load spacing", 32'(acc_cyc[9] - acc_cyc[8]), 32'd6);
    chk("ro port untouched", mem1[8'hFD], 32'hA500_00FD);

    // Held response: load 0x40 with rsp_ready low, plus a store offered while busy.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h40; req_wdata = 32'h0; rsp_ready = 1'b0;
    @(negedge clk);
    req_we = 1'b1; req_addr = 8'h41; req_wdata = 32'hFFFF_FFFF;
    n = 1;
    while (!bus1.rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stall first rsp latency", 32'(n), 32'd3);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall c%0d rsp_valid", k), 32'(bus1.rsp_valid), 32'd1);
      chk($sformatf("stall c%0d rdata", k), bus1.rsp_rdata, 32'hA500_0040);
      chk($sformatf("stall c%0d req_ready", k), 32'(bus1.req_ready), 32'd0);
      @(negedge clk);
    end
    chk("stall RL3 rsp_valid", 32'(bus3.rsp_valid), 32'd1);
    chk("stall RL3 rdata", bus3.rsp_rdata, 32'hA500_0040);
    chk("stall no stray write", mem1[8'h41], 32'hA500_0041);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall release req_ready", 32'(bus1.req_ready), 32'd1);
    chk("stall release rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("stall release RL3 idle", 32'(bus3.req_ready), 32'd1);

    // Reset in the middle of a load's WAIT phase.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h40; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("midrst mem_write_en", 32'(bus1.mem_write_en), 32'd0);
    chk("midrst req_ready", 32'(bus1.req_ready), 32'd1);
    chk("midrst rdata", bus1.rsp_rdata, 32'd0);
    chk("midrst mem_addr", 32'(bus1.mem_addr), 32'd0);
    chk("midrst RL3 req_ready", 32'(bus3.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus1.rsp_valid || bus3.rsp_valid) seen++;
    end
    chk("midrst dropped response", 32'(seen), 32'd0);
    v = '{1'b1, 8'h80, 32'h3333_3333, 32'h0000_0000, 1'b0, 1};
    do_txn("post-rst store", v);
    v = '{1'b0, 8'h80, 32'h0000_0000, 32'h3333_3333, 1'b0, 0};
    do_txn("post-rst load", v);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_initiator.md
MEM_ACCESS_INITIATOR -- requirements
Module: mem_access_initiator

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, memory word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, memory read latency in cycles; legal range 1..3.
REQ-004 The block SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port req_valid  in  1  request offered.
REQ-007 The block SHALL have port req_ready  out  1  request accepted when high together with req_valid.
REQ-008 The block SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-009 The block SHALL have port req_addr  in  ADDR_WIDTH  target word address.
REQ-010 The block SHALL have port req_wdata  in  DATA_WIDTH  store data.
REQ-011 The block SHALL have port rsp_valid  out  1  response available.
REQ-012 The block SHALL have port rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-013 The block SHALL have port rsp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors.
REQ-014 The block SHALL have port rsp_err  out  1  request rejected (store to read-only port).
REQ-015 The block SHALL have port mem_addr  out  ADDR_WIDTH  address to memory unit.
REQ-016 The block SHALL have port mem_write_en  out  1  memory write strobe.
REQ-017 The block SHALL have port mem_data_in  out  DATA_WIDTH  write data to memory unit.
REQ-018 The block SHALL have port mem_data_out  in  DATA_WIDTH  read data from memory unit.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 On the accept edge (IDLE, req_valid=1), the block SHALL register req_we, req_addr, req_wdata and enter ISSUE.
REQ-021 From ISSUE through the sampling edge, mem_addr and mem_data_in SHALL hold the registered values; in IDLE and RESP they SHALL hold their last values.
REQ-022 Store to an address other than 0xFD/0xFE: mem_write_en SHALL be 1 for exactly the one ISSUE cycle; next state RESP with rsp_rdata=0, rsp_err=0.
REQ-023 Store to 0xFD or 0xFE (input ports, read-only): mem_write_en SHALL stay 0; next state RESP with rsp_err=1, rsp_rdata=0.
REQ-024 Store to 0xFF SHALL be issued as a normal write (output port).
REQ-025 Load: ISSUE (mem_write_en=0) SHALL be followed by exactly READ_LATENCY WAIT cycles; mem_data_out SHALL be sampled into rsp_rdata on the edge ending the last WAIT cycle; next state RESP.
REQ-026 Latency: rsp_valid SHALL first be high 2 cycles after the accept edge for stores and 2+READ_LATENCY cycles for loads.
REQ-027 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be stable until the edge with rsp_ready=1, then the FSM SHALL return to IDLE.
REQ-028 rsp_ready held high SHALL give one transaction per 3 cycles (store) or 3+READ_LATENCY cycles (load); a new request SHALL NOT be accepted in the RESP exit cycle.
REQ-029 req_valid while req_ready=0 SHALL be ignored, with no side effects.
REQ-030 The WAIT counter SHALL be sized for 3 and SHALL reload on every ISSUE entry.

Reset
REQ-031 Asserting rst at any time SHALL immediately force state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_write_en=0, mem_addr=0, mem_data_in=0, WAIT counter=0.
REQ-032 A transaction interrupted by reset SHALL be dropped, with no response; the first accept after rst deasserts SHALL behave as from power-up.

Structure
REQ-033 Package mem_access_pkg SHALL hold the FSM state enum and constants PORT0_ADDR=8'hFD, PORT1_ADDR=8'hFE, OUTPORT_ADDR=8'hFF.
REQ-034 The WAIT down-counter SHALL be one sub-module, mem_latency_counter (load, decrement, done).

Verification
REQ-035 Store addr 0x00 data 0x12345678, rsp_ready=1 -> single mem_write_en pulse with mem_addr=0x00; rsp_valid 2 cycles after accept, rsp_err=0.
REQ-036 Load 0x00 after REQ-035, READ_LATENCY=1 and 3 -> rsp_rdata=0x12345678 at 3 and 5 cycles after accept respectively.
REQ-037 Store 0xFD data 0xDEADBEEF -> no mem_write_en, rsp_err=1; store 0xFF data 0xAABBCCDD -> mem_write_en pulse, rsp_err=0.
REQ-038 Load 0x40, rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, extra req_valid ignored.
REQ-039 rst asserted during WAIT of a load -> rsp_valid=0 and mem_write_en=0 immediately, no response emitted; next store 0x80 data 0x33333333 completes normally.
REQ-040 Back-to-back stores 0x10/0x11111111 and 0xC0/0x44444444 with rsp_ready=1 -> accepts 3 cycles apart; loads then return 0x11111111 and 0x44444444.
